// File: rtl/song_sequencer.sv
// ---------------------------------------------------------------------------
// song_sequencer
//
// Steps through the notes of the selected song for the music player. For
// each note it addresses the song ROM, captures the {note, duration} word,
// presents it with a one-cycle new_note pulse, and then waits for the note
// player to report note_done before moving on. When the last note of the
// song completes, it sends a one-cycle song_done pulse back to the mcu. It
// then parks until restart or reset.
//
// Optional feature (compile-time macro SONG_END_MARKER_EN):
//   defined   - a ROM word with a zero duration field marks the end of the
//               song. That word is not issued, and the song finishes early.
//   undefined - a zero-duration word is issued as an ordinary note, and
//               every song runs all 2**IDX_W notes.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   play       in   1 = allowed to fetch and issue the next note
//   song       in   selected song (upper ROM address bits)
//   restart    in   synchronous clear from the mcu (reset_player)
//   note_done  in   1-cycle pulse: current note finished playing
//   rom_addr   out  {song, idx}, combinational
//   rom_data   in   {note, duration}; registered ROM, valid 1 cycle after addr
//   new_note   out  1-cycle pulse; note/duration are valid
//   note       out  registered note code
//   duration   out  registered note duration
//   song_done  out  1-cycle pulse after the last note completes
// ---------------------------------------------------------------------------
module song_sequencer #(
   parameter int NOTE_W = 6,
   parameter int DUR_W  = 6,
   parameter int IDX_W  = 5,
   parameter int SONG_W = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      play,
   input  logic [SONG_W-1:0]         song,
   input  logic                      restart,
   input  logic                      note_done,
   output logic [SONG_W+IDX_W-1:0]   rom_addr,
   input  logic [NOTE_W+DUR_W-1:0]   rom_data,
   output logic                      new_note,
   output logic [NOTE_W-1:0]         note,
   output logic [DUR_W-1:0]          duration,
   output logic                      song_done
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT_ROM,
      ST_EMIT,
      ST_WAIT_DONE,
      ST_DONE,
      ST_END
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = '1;

   state_t            state;
   logic [IDX_W-1:0]  idx;

   // Fields of the ROM word as it arrives during WAIT_ROM.
   logic [NOTE_W-1:0] rom_note;
   logic [DUR_W-1:0]  rom_dur;
   logic              end_marker;

   assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
   assign rom_dur  = rom_data[DUR_W-1:0];

`ifdef SONG_END_MARKER_EN
   assign end_marker = (rom_dur == '0);
`else
   assign end_marker = 1'b0;
`endif

   // The ROM is addressed straight from the live song select. A song change
   // mid-song therefore moves the address without touching idx. The mcu is
   // expected to issue restart along with any song change.
   assign rom_addr = {song, idx};

   // NOTE: all sequential state uses non-blocking assignments, so every
   // register in this block samples the pre-edge values of the others.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         idx       <= '0;
         note      <= '0;
         duration  <= '0;
         new_note  <= 1'b0;
         song_done <= 1'b0;
      end else if (restart) begin
         // restart wins over everything, including a coincident note_done.
         state     <= ST_IDLE;
         idx       <= '0;
         note      <= '0;
         duration  <= '0;
         new_note  <= 1'b0;
         song_done <= 1'b0;
      end else begin
         // The pulse outputs default low. They are raised only on the edge
         // that enters EMIT or DONE, so each one lasts exactly one cycle.
         new_note  <= 1'b0;
         song_done <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (play) state <= ST_FETCH;
            end

            // The address is presented during this cycle. The registered ROM
            // returns the word during WAIT_ROM.
            ST_FETCH: begin
               state <= ST_WAIT_ROM;
            end

            ST_WAIT_ROM: begin
               if (end_marker) begin
                  // The marker word is not issued. note/duration keep the
                  // previous note's value.
                  state     <= ST_DONE;
                  song_done <= 1'b1;
               end else begin
                  note     <= rom_note;
                  duration <= rom_dur;
                  new_note <= 1'b1;
                  state    <= ST_EMIT;
               end
            end

            ST_EMIT: begin
               state <= ST_WAIT_DONE;
            end

            // play only gates the fetch of the next note. A note that is
            // already playing always runs to note_done.
            ST_WAIT_DONE: begin
               if (note_done) begin
                  if (idx == LAST_IDX) begin
                     // idx never wraps. It stays on the last note.
                     state     <= ST_DONE;
                     song_done <= 1'b1;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= play ? ST_FETCH : ST_IDLE;
                  end
               end
            end

            ST_DONE: begin
               state <= ST_END;
            end

            // Parked until restart or reset. song_done is not repeated.
            ST_END: begin
               state <= ST_END;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_song_sequencer.sv
// ---------------------------------------------------------------------------
// tb_song_sequencer
//
// Directed walk through the song sequencer's behaviour: reset values, first
// note latency and word capture, play gating, asynchronous reset mid-note,
// restart racing note_done, a full 32-note song with random play pauses and
// the final song_done pulse, and the zero-duration word.
//
// The ROM contents are random. Expected words come from the bench's own copy
// of the ROM, indexed by a note counter the bench keeps itself.
// ---------------------------------------------------------------------------
module tb_song_sequencer;

   localparam int NOTE_W = 6;
   localparam int DUR_W  = 6;
   localparam int IDX_W  = 5;
   localparam int SONG_W = 2;
   localparam int NOTES  = 2 ** IDX_W;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     play;
   logic [SONG_W-1:0]        song;
   logic                     restart;
   logic                     note_done;
   logic [SONG_W+IDX_W-1:0]  rom_addr;
   logic [NOTE_W+DUR_W-1:0]  rom_data;
   logic                     new_note;
   logic [NOTE_W-1:0]        note;
   logic [DUR_W-1:0]         duration;
   logic                     song_done;

   logic [NOTE_W+DUR_W-1:0]  mem [0:(2**(SONG_W+IDX_W))-1];

   int n_cmp = 0;
   int n_err = 0;

   song_sequencer #(
      .NOTE_W(NOTE_W), .DUR_W(DUR_W), .IDX_W(IDX_W), .SONG_W(SONG_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .play      (play),
      .song      (song),
      .restart   (restart),
      .note_done (note_done),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .new_note  (new_note),
      .note      (note),
      .duration  (duration),
      .song_done (song_done)
   );

   always #5 clk = ~clk;

   // Registered song ROM: the word appears one cycle after its address.
   always @(posedge clk) rom_data <= mem[rom_addr];

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Outputs are sampled and inputs are driven 1 time unit after each edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for a pulse on new_note (want_done=0) or song_done (want_done=1).
   // It checks the pulse's latency from the last input change, that the
   // other pulse did not fire, and that the pulse lasts exactly one cycle.
   // note_done is dropped after the first edge.
   task automatic wait_pulse(input string tag, input bit want_done, input int exp_lat);
      int lat   = 0;
      bit stray = 1'b0;
      for (int i = 1; i <= 8 && lat == 0; i++) begin
         tick();
         note_done = 1'b0;
         if ((want_done ? song_done : new_note) === 1'b1) lat = i;
         if ((want_done ? new_note : song_done) === 1'b1) stray = 1'b1;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_other_pulse"}, {31'd0, stray}, 32'd0);
      tick();
      check({tag, "_one_cycle"}, {31'd0, (want_done ? song_done : new_note)}, 32'd0);
   endtask

   // Expects note number idx of the current song to be issued.
   task automatic wait_note(input string tag, input int idx);
      logic [NOTE_W+DUR_W-1:0] w;
      w = mem[{song, idx[IDX_W-1:0]}];
      wait_pulse(tag, 1'b0, 3);
      check({tag, "_note"}, note, w[NOTE_W+DUR_W-1:DUR_W]);
      check({tag, "_dur"}, duration, w[DUR_W-1:0]);
      check({tag, "_addr"}, rom_addr, {song, idx[IDX_W-1:0]});
   endtask

   // Runs n cycles with the inputs held and expects no pulse at all.
   task automatic expect_quiet(input string tag, input int n);
      int seen = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (new_note === 1'b1 || song_done === 1'b1) seen++;
      end
      check(tag, seen, 0);
   endtask

   initial begin
      bit ended;
      int last_idx;

      // Random ROM contents. Non-zero durations keep the end marker out of
      // the random data, and the zero-duration word is placed deliberately.
      for (int i = 0; i < 2 ** (SONG_W + IDX_W); i++) begin
         mem[i] = NOTE_W'(0) + 12'($urandom);
         if (mem[i][DUR_W-1:0] == '0) mem[i][0] = 1'b1;
      end
      mem[7'h40] = 12'h2A5;
      mem[{2'd1, 5'd3}] = {6'h15, 6'h00};

      reset = 1'b1; play = 1'b0; song = '0; restart = 1'b0; note_done = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Reset values.
      check("rst_new_note", new_note, 0);
      check("rst_song_done", song_done, 0);
      check("rst_note", note, 0);
      check("rst_dur", duration, 0);
      check("rst_addr", rom_addr, 0);
      expect_quiet("rst_idle", 4);

      // First note of song 2.
      song = 2'd2;
      play = 1'b1;
      #1;
      check("t2_addr0", rom_addr, 7'h40);
      wait_note("t2_n0", 0);
      check("t2_note_val", note, 6'h0A);
      check("t2_dur_val", duration, 6'h25);

      // play low in WAIT_DONE: the note completes, then the sequencer idles.
      play = 1'b0;
      tick();
      note_done = 1'b1;
      tick();
      note_done = 1'b0;
      check("t3_addr1", rom_addr, 7'h41);
      expect_quiet("t3_idle10", 10);
      play = 1'b1;
      wait_note("t3_n1", 1);

      for (int k = 2; k <= 4; k++) begin
         note_done = 1'b1;
         wait_note("t1_adv", k);
      end

      // Asynchronous reset between edges, in WAIT_DONE at idx 4.
      play = 1'b0;
      #3 reset = 1'b1;
      #1;
      check("t1_async_new_note", new_note, 0);
      check("t1_async_song_done", song_done, 0);
      check("t1_async_note", note, 0);
      check("t1_async_dur", duration, 0);
      check("t1_async_addr", rom_addr, {2'd2, 5'd0});
      @(negedge clk);
      reset = 1'b0;
      expect_quiet("t1_post_rst", 5);
      check("t1_post_addr", rom_addr, {2'd2, 5'd0});

      // restart and note_done in the same cycle at idx 5.
      play = 1'b1;
      wait_note("t5_n0", 0);
      for (int k = 1; k <= 5; k++) begin
         note_done = 1'b1;
         wait_note("t5_adv", k);
      end
      restart = 1'b1;
      note_done = 1'b1;
      play = 1'b0;
      tick();
      restart = 1'b0;
      note_done = 1'b0;
      check("t5_addr", rom_addr, {2'd2, 5'd0});
      check("t5_note", note, 0);
      check("t5_dur", duration, 0);
      check("t5_new_note", new_note, 0);
      check("t5_song_done", song_done, 0);
      expect_quiet("t5_idle", 4);
      play = 1'b1;
      #1;
      check("t5_addr_play", rom_addr, {2'd2, 5'd0});
      wait_note("t5_restart_n0", 0);

      // Full run of song 1 with random play pauses between notes.
      restart = 1'b1;
      play = 1'b0;
      song = 2'd1;
      tick();
      restart = 1'b0;
      play = 1'b1;
      wait_note("t4_n0", 0);
      ended = 1'b0;
      last_idx = NOTES - 1;
      for (int k = 1; k < NOTES && !ended; k++) begin
         expect_quiet("t4_hold", $urandom_range(0, 2));
         if ($urandom_range(0, 2) == 0) begin
            play = 1'b0;
            note_done = 1'b1;
            tick();
            note_done = 1'b0;
            check("t4_pause_addr", rom_addr, {2'd1, 5'(k)});
            expect_quiet("t4_pause", 3);
            play = 1'b1;
         end else begin
            note_done = 1'b1;
         end
`ifdef SONG_END_MARKER_EN
         if (k == 3) begin
            wait_pulse("t6_marker", 1'b1, 3);
            check("t6_note_kept", note, mem[{2'd1, 5'd2}][NOTE_W+DUR_W-1:DUR_W]);
            ended = 1'b1;
            last_idx = 3;
         end else begin
            wait_note("t4_note", k);
         end
`else
         wait_note("t4_note", k);
         if (k == 3) check("t6_zero_dur", duration, 0);
`endif
      end

      if (!ended) begin
         note_done = 1'b1;
         wait_pulse("t4_song_done", 1'b1, 1);
      end
      check("t4_end_addr", rom_addr, {2'd1, 5'(last_idx)});

      // END is sticky: play and note_done toggles have no effect.
      for (int i = 0; i < 20; i++) begin
         play = 1'($urandom);
         note_done = 1'($urandom);
         tick();
         check("t4_end_new_note", new_note, 0);
         check("t4_end_song_done", song_done, 0);
      end
      note_done = 1'b0;
      check("t4_end_addr_hold", rom_addr, {2'd1, 5'(last_idx)});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
Steps through the notes of the currently selected song for the music player. Sits between the mcu (play, song, reset_player) and the note player. For each note it reads a song ROM, presents note/duration with a one-cycle new_note pulse, and waits for note_done before advancing. After the last note it pulses song_done back to the mcu.

Parameters:
NOTE_W, 6, note code width
DUR_W, 6, duration width
IDX_W, 5, note index width; notes per song = 2**IDX_W
SONG_W, 2, song select width

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
play  input  1  from mcu; 1 = allowed to fetch and issue notes
song  input  SONG_W  from mcu; selected song
restart  input  1  synchronous clear, driven by mcu reset_player
note_done  input  1  from note player; current note finished (1-cycle pulse)
rom_addr  output  SONG_W+IDX_W  song ROM address = {song, idx}, combinational
rom_data  input  NOTE_W+DUR_W  ROM word {note, duration}; registered ROM, valid 1 cycle after rom_addr
new_note  output  1  1-cycle pulse; note/duration valid
note  output  NOTE_W  registered note code
duration  output  DUR_W  registered duration
song_done  output  1  1-cycle pulse after last note completes

Behaviour:
- Reset (async, active-high): state=IDLE, idx=0, note=0, duration=0, new_note=0, song_done=0.
- restart (sync): highest priority after reset, in any state. Next edge: state=IDLE, idx=0, note=0, duration=0, new_note=0, song_done=0. Beats note_done in the same cycle.
- States: IDLE, FETCH, WAIT_ROM, EMIT, WAIT_DONE, DONE, END.
- IDLE: play=1 -> FETCH; otherwise hold.
- FETCH: rom_addr presented -> WAIT_ROM (unconditional).
- WAIT_ROM: at the exit edge, note <= rom_data[NOTE_W+DUR_W-1:DUR_W] and duration <= rom_data[DUR_W-1:0] -> EMIT.
- EMIT: new_note=1 for exactly this cycle -> WAIT_DONE.
- WAIT_DONE: on note_done:
  - idx==2**IDX_W-1 -> DONE.
  - otherwise idx<=idx+1, then FETCH if play=1, else IDLE.
- DONE: song_done=1 for exactly this cycle -> END.
- END: hold. song_done is not repeated. Leave only via restart or reset.
- Latency: play seen high in IDLE at edge N -> new_note high in the cycle after edge N+2 (FETCH, WAIT_ROM, EMIT).
- note_done is ignored outside WAIT_DONE.
- play=0 does not abort a note in WAIT_DONE. It only blocks the fetch of the next note.
- rom_addr = {song, idx} at all times. A song change mid-song only changes the address; idx is not cleared. The mcu must assert restart on a song change.
- idx never wraps; the last note always goes to DONE.
- new_note and song_done are never high in the same cycle.
- note/duration hold their value until the next capture or a clear.

Optional Feature:
Macro SONG_END_MARKER_EN.
- Defined: in WAIT_ROM, if the rom_data duration field == 0, the word is an end marker. Next state is DONE; note/duration are not updated; no new_note pulse. The song ends early.
- Undefined: a zero-duration word is issued as a normal note. The song always runs all 2**IDX_W notes.

Test Plan:
1. Reset asserted between clock edges, with the FSM in WAIT_DONE at idx=4 -> outputs 0 immediately; rom_addr={song,0} after release.
2. song=2, play=1, rom_data=12'h2A5 -> rom_addr=7'h40; new_note high for 1 cycle, 3 cycles after play is sampled; note=6'h0A, duration=6'h25. Then note_done -> rom_addr=7'h41, next new_note follows.
3. play=0 during WAIT_DONE, then note_done -> idx=1, FSM in IDLE, no new_note for 10 cycles. play=1 -> new_note 3 cycles later.
4. Run to idx=31, then note_done -> song_done high for exactly 1 cycle. Further note_done and play toggles produce no new_note and no song_done.
5. restart and note_done in the same cycle at idx=5 -> IDLE, idx=0, note=0, no song_done. Then play=1 -> rom_addr={song,5'd0}.
6. With SONG_END_MARKER_EN defined, rom_data duration=0 at idx=3 -> no new_note, song_done pulse, END. Without it -> new_note pulse with duration=0.
